// File: rtl/fifo_rd_ptr_empty.sv
// Read-side pointer stage of the async FIFO: synchronizes the write Gray pointer,
// advances the read pointer and registers empty, fill level and sticky underflow.
module fifo_rd_ptr_empty #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic [N-1:0] wptr_gray,
   input  logic         clr_uflow,
   output logic [N-1:0] rptr_gray,
   output logic [N-2:0] raddr,
   output logic         empty,
   output logic [N-1:0] level,
   output logic         underflow
);

   logic [N-1:0] wq1_q, wq2_q;
   logic [N-1:0] rbin_q, rbin_d;
   logic [N-1:0] rptr_gray_q, rptr_gray_d;
   logic         empty_q, empty_d;
   logic [N-1:0] level_q, level_d;
   logic         underflow_q, underflow_d;
   logic         rd_en;
   logic [N-1:0] wbin_s;

   function automatic logic [N-1:0] gray2bin(input logic [N-1:0] g);
      logic [N-1:0] b;
      b[N-1] = g[N-1];
      for (int i = N - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   always_comb begin
      rd_en       = inc & ~empty_q;
      rbin_d      = rbin_q + {{(N-1){1'b0}}, rd_en};
      rptr_gray_d = rbin_d ^ (rbin_d >> 1);
      wbin_s      = gray2bin(wq2_q);
      // Compare against the pointer after this cycle's read so empty lands on the same edge.
      empty_d     = (rptr_gray_d == wq2_q);
      level_d     = wbin_s - rbin_d;
      underflow_d = (inc & empty_q) | (underflow_q & ~clr_uflow);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wq1_q       <= '0;
         wq2_q       <= '0;
         rbin_q      <= '0;
         rptr_gray_q <= '0;
         empty_q     <= 1'b1;
         level_q     <= '0;
         underflow_q <= 1'b0;
      end else begin
         wq1_q       <= wptr_gray;
         wq2_q       <= wq1_q;
         rbin_q      <= rbin_d;
         rptr_gray_q <= rptr_gray_d;
         empty_q     <= empty_d;
         level_q     <= level_d;
         underflow_q <= underflow_d;
      end
   end

   assign rptr_gray = rptr_gray_q;
   assign raddr     = rbin_q[N-2:0];
   assign empty     = empty_q;
   assign level     = level_q;
   assign underflow = underflow_q;

endmodule
